// File: rtl/cic3_sample_fifo.sv
// Capture stage behind the CIC3 decimator: detects comb-clock updates, drops the start-up
// transient, converts to a saturated signed sample and buffers it in a show-ahead FIFO.
module cic3_sample_fifo #(
    parameter int unsigned DECIMATION_FACTOR = 256,
    parameter int unsigned CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
    parameter int unsigned NUMBITS           = 3*CLOCK_WIDTH+1,
    parameter int unsigned OUT_WIDTH         = 16,
    parameter int unsigned FIFO_DEPTH        = 8,
    parameter int unsigned SETTLE_SAMPLES    = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          divided_clk,
    input  logic [NUMBITS-1:0]            cic_in,
    input  logic                          rd_en,
    input  logic                          clear_overflow,
    output logic [OUT_WIDTH-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SET_W = $clog2(SETTLE_SAMPLES + 1);
    localparam int unsigned SHIFT = NUMBITS - 1 - OUT_WIDTH;
    localparam int unsigned C_W   = NUMBITS + 1;
    localparam logic [C_W-1:0] MIDSCALE = C_W'(1) << (NUMBITS - 2);
    localparam logic [C_W-1:0] SAT_MAX  = C_W'((1 << (OUT_WIDTH - 1)) - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

    state_t                state, state_nxt;
    logic [SET_W-1:0]      settle_cnt, settle_nxt;
    logic                  div_q1, div_q2, cap_strobe;
    logic                  wr_req, flush, pop, push, drop, full;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]      count_nxt;
    logic signed [C_W-1:0] conv_c, conv_s;
    logic [OUT_WIDTH-1:0]  sample;
    logic [OUT_WIDTH-1:0]  mem [FIFO_DEPTH];

    // Rising-edge detect on the comb clock, delayed one more cycle so the comb output settles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q1     <= 1'b0;
            div_q2     <= 1'b0;
            cap_strobe <= 1'b0;
        end else begin
            div_q1     <= divided_clk;
            div_q2     <= div_q1;
            cap_strobe <= div_q1 & ~div_q2;
        end
    end

    // Offset-binary to two's complement, floor shift, clamp the single positive full-scale code
    always_comb begin
        conv_c = $signed({1'b0, cic_in}) - $signed(MIDSCALE);
        conv_s = conv_c >>> SHIFT;
        if (conv_s > $signed(SAT_MAX)) begin
            sample = SAT_MAX[OUT_WIDTH-1:0];
        end else begin
            sample = conv_s[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        wr_req     = 1'b0;
        flush      = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            flush     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                end
                SETTLE: begin
                    if (cap_strobe) begin
                        settle_nxt = settle_cnt + SET_W'(1);
                        if (settle_cnt == SET_W'(SETTLE_SAMPLES - 1)) begin
                            state_nxt = RUN;
                        end
                    end
                end
                RUN:     wr_req    = cap_strobe;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A write on a full FIFO is accepted only when a pop frees the slot on the same edge
    always_comb begin
        full       = (fifo_count == CNT_W'(FIFO_DEPTH));
        pop        = rd_en & rd_valid;
        push       = wr_req & (~full | pop);
        drop       = wr_req & full & ~pop;
        rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nxt  = fifo_count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample;
        end
    end

    // rd_data is registered and tracks the next head; it holds when the FIFO goes empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= drop | (overflow & ~clear_overflow);
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
                rd_valid   <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                rd_ptr     <= rd_ptr_nxt;
                fifo_count <= count_nxt;
                rd_valid   <= (count_nxt != '0);
                if (count_nxt != '0) begin
                    rd_data <= (push && (wr_ptr == rd_ptr_nxt)) ? sample : mem[rd_ptr_nxt];
                end
            end
        end
    end

endmodule
